// File: rtl/moving_average_pow2_pkg.sv
// Purpose: shared defaults and the window-select clamp for the moving-average filter.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package moving_average_pow2_pkg;

  localparam int MA_DATA_W          = 16;
  localparam int MA_LOG2_MAX_WINDOW = 6;

  // Window selects above the buffer depth saturate to the largest window.
  function automatic int clamp_window_log2(input int sel, input int max_log2);
    return (sel > max_log2) ? max_log2 : sel;
  endfunction

endpackage

// File: rtl/ma_sample_buffer.sv
// Purpose: circular sample store with a write pointer and a read port at a fixed offset behind it.
// Latency: write lands on the clock edge; read is combinational from the current pointer.
// Backpressure: none; a write happens on every cycle wr_en is high.
module ma_sample_buffer #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DEPTH_LOG2-1:0] rd_offset,
  output logic [DATA_W-1:0]     rd_data
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0]     mem [0:DEPTH-1];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_addr;

  // An offset equal to the full depth wraps to 0, i.e. the slot about to be
  // overwritten, which holds the oldest sample of a full-depth window.
  assign rd_addr = wr_ptr - rd_offset;
  assign rd_data = mem[rd_addr];

  // Advance the write pointer once per stored sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // Sample storage is never cleared; the fill counter upstream masks stale entries.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: rtl/moving_average_pow2.sv
// Purpose: signed moving average over a runtime-selectable 2^k window, round-half-up, flush on window change.
// Latency: 2 clocks from accepted sample to out_valid/out_data; one sample per clock sustained.
// Backpressure: none; in_valid gaps stall the pipeline and out_valid repeats the same gaps.
module moving_average_pow2
  import moving_average_pow2_pkg::*;
#(
  parameter int DATA_W          = MA_DATA_W,
  parameter int LOG2_MAX_WINDOW = MA_LOG2_MAX_WINDOW,
  parameter int WIN_SEL_W       = $clog2(LOG2_MAX_WINDOW + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    in_data,
  input  logic [WIN_SEL_W-1:0] window_log2,
  output logic                 out_valid,
  output logic [DATA_W-1:0]    out_data,
  output logic                 filled
);

  localparam int ACC_W = DATA_W + LOG2_MAX_WINDOW;
  localparam int CNT_W = LOG2_MAX_WINDOW + 1;

  // Window control
  logic [WIN_SEL_W-1:0] win_sel;
  logic [WIN_SEL_W-1:0] win_q;
  logic [WIN_SEL_W-1:0] k_eff;
  logic                 win_change;
  logic [CNT_W-1:0]     n_q;
  logic [CNT_W-1:0]     n_eff;

  // Accumulate stage
  logic signed [DATA_W-1:0] x_new;
  logic signed [DATA_W-1:0] x_old;
  logic        [DATA_W-1:0] buf_rd;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_next;
  logic        [CNT_W-1:0]  fill_cnt;
  logic        [CNT_W-1:0]  fill_next;
  logic                     hit;
  logic                     v1;
  logic [WIN_SEL_W-1:0]     k1;

  // Rounding stage
  logic signed [ACC_W:0] bias;
  logic signed [ACC_W:0] rnd_sum;
  logic signed [ACC_W:0] rnd_shift;

  assign win_sel    = WIN_SEL_W'(clamp_window_log2(int'(window_log2), LOG2_MAX_WINDOW));
  assign win_change = (win_sel != win_q);
  assign k_eff      = win_change ? win_sel : win_q;
  assign n_q        = CNT_W'(1) << win_q;
  assign n_eff      = CNT_W'(1) << k_eff;

  assign x_new  = in_data;
  assign filled = (fill_cnt == n_q);

  ma_sample_buffer #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (LOG2_MAX_WINDOW)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (in_valid),
    .wr_data   (in_data),
    .rd_offset (n_q[LOG2_MAX_WINDOW-1:0]),
    .rd_data   (buf_rd)
  );

  // Until the window is full the departing sample does not exist yet; mask whatever the buffer holds.
  assign x_old = (fill_cnt < n_q) ? '0 : buf_rd;

  // Next accumulator and fill count; a window change restarts both, seeded by a same-cycle sample.
  always_comb begin
    acc_next  = acc;
    fill_next = fill_cnt;
    if (win_change) begin
      acc_next  = in_valid ? ACC_W'(x_new) : '0;
      fill_next = in_valid ? CNT_W'(1) : '0;
    end else if (in_valid) begin
      acc_next  = acc + ACC_W'(x_new) - ACC_W'(x_old);
      fill_next = (fill_cnt == n_q) ? fill_cnt : fill_cnt + 1'b1;
    end
    hit = in_valid && (fill_next == n_eff);
  end

  // Round half up: add half an LSB of the result, then arithmetic shift; k = 0 passes acc through.
  always_comb begin
    bias      = ((ACC_W+1)'(1) << k1) >>> 1;
    rnd_sum   = {acc[ACC_W-1], acc} + bias;
    rnd_shift = rnd_sum >>> k1;
  end

  // Two-stage pipeline: window/accumulator state, then the registered rounded mean.
  always_ff @(posedge clk) begin
    if (reset) begin
      win_q     <= '0;
      acc       <= '0;
      fill_cnt  <= '0;
      v1        <= 1'b0;
      k1        <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      win_q     <= win_sel;
      acc       <= acc_next;
      fill_cnt  <= fill_next;
      v1        <= hit;
      k1        <= k_eff;
      out_valid <= v1;
      if (v1) begin
        out_data <= DATA_W'(rnd_shift);
      end
    end
  end

endmodule

// File: doc/moving_average_pow2.md
# moving_average_pow2

Parametrised, signed moving-average filter with a runtime-selectable power-of-two window, up to 2^LOG2_MAX_WINDOW samples. It accepts a sample stream qualified by a valid strobe and emits one rounded mean per accepted sample once the window is full. When the window size changes it flushes and refills automatically. It sits in the shaper data path wherever a fixed-window averager is required, and adds valid handshaking, full signed-range correctness, rounding and safe window switching.

## Interface
- DATA_W, 16: sample and output width, two's complement.
- LOG2_MAX_WINDOW, 6: log2 of the maximum window (64); sets sample buffer depth.
- WIN_SEL_W, $clog2(LOG2_MAX_WINDOW+1): width of window_log2.
- clk  in  1  sole clock; all logic on posedge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- in_valid  in  1  qualifies in_data; one sample accepted per high cycle.
- in_data  in  DATA_W  signed sample.
- window_log2  in  WIN_SEL_W  window N = 2^k; values > LOG2_MAX_WINDOW clamp to LOG2_MAX_WINDOW.
- out_valid  out  1  single-cycle strobe per produced mean.
- out_data  out  DATA_W  signed rounded mean; holds between strobes.
- filled  out  1  high while N samples have been accepted since the last flush.

## Operation
- Circular buffer of 2^LOG2_MAX_WINDOW samples, written at wr_ptr on each accepted sample; old sample = buf[wr_ptr − N], read combinationally.
- Old sample forced to 0 while fill_cnt < N; buffer contents are never cleared, so stale data must not leak.
- Accumulator ACC_W = DATA_W + LOG2_MAX_WINDOW bits, signed: acc <= acc + x_new − x_old on each accepted sample; no saturation is needed, and the accumulator never wraps.
- fill_cnt increments per accepted sample, saturating at N; filled = (fill_cnt == N).
- Rounding is round-half-up: out = (acc + 2^(k−1)) >>> k; with k = 0, out = acc. The result always fits in DATA_W; the −1.5 → −1 and 2.5 → 3 cases are required.
- k and a valid flag are pipelined alongside acc, so each output uses the k in effect when its sample was accepted.
- Window change: registered win_q is compared against clamp(window_log2) every cycle. On mismatch, win_q updates, and acc and fill_cnt clear on the next edge.
  - If in_valid is high in the change cycle, that sample becomes the first sample of the new window: acc = x_new, fill_cnt = 1.
  - An out_valid already in flight from a pre-change sample is still emitted.
- out_valid is asserted for an accepted sample only if fill_cnt reaches N with that sample.
- Reset: acc, fill_cnt, wr_ptr, win_q (k = 0), out_data, out_valid and filled all go to 0. A non-zero window_log2 after reset triggers a normal flush.

## Timing
- Latency is 2 clocks:
  - Sample accepted at edge t.
  - acc updated at t+1.
  - out_data and out_valid registered at t+2.
- Full throughput: one sample per clock, back-to-back; in_valid gaps simply stall, and out_valid follows with the same gaps.
- filled updates at t+1 together with acc.
- reset asserted mid-stream: on the next edge all state clears and out_valid is low. Any in-flight result is discarded.

## Structure
- package_settings gains MA_DATA_W and MA_LOG2_MAX_WINDOW defaults, and a clamp_window_log2 function shared with the bench.
- Sub-module ma_sample_buffer holds the circular buffer, the write pointer and the offset read port (parameters: DATA_W, DEPTH_LOG2).
- The top level holds the fill counter, window-change detect, accumulator and rounding stage.

## Test plan
- Constant input: reset, k = 2, in_data = 100 continuous → first out_valid 2 clocks after the 4th sample, out = 100 every cycle after; filled rises with the 4th sample.
- Step response: k = 3, 0 → 1000 step after the window is full → outputs 125, 250, …, 1000 over 8 samples.
- Rounding, k = 1:
  - Pairs (1, 2) → 2.
  - (−1, −2) → −1.
  - (2, 3) → 3.
  - (−3, −4) → −3.
- Extremes, DATA_W = 16, k = 6: 64 samples of −32768 → −32768; then 64 of 32767 → 32767; no wrap at any intermediate output.
- Window switching:
  - k 2 → 1 mid-stream: filled drops, the in-flight output is still emitted, and the next out_valid comes after 2 new samples with their mean.
  - window_log2 = 7 behaves exactly as 6.
- Gaps and reset:
  - Random in_valid gaps → outputs match a golden model sample for sample.
  - reset pulsed mid-stream → out_valid = 0 next cycle, and refill starts from zero with no stale samples in the mean.
